// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Takes 32-bit instruction words from a valid/ready stream and
//            writes them big-endian, one byte per cycle, into a byte-wide
//            instruction memory starting at a programmable base address.
// Option   : define IMEM_LOADER_CHECKSUM_EN to build the 8-bit running
//            byte-sum output; otherwise checksum is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [7:0]        checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_q, byte_d;
    logic              wrapped_q, wrapped_d;
    logic [7:0]        byte_w;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        ck_q, ck_d;
`endif

    // Select the current byte of the captured word, MSB first
    always_comb begin
        case (byte_q)
            2'd0:    byte_w = word_q[31:24];
            2'd1:    byte_w = word_q[23:16];
            2'd2:    byte_w = word_q[15:8];
            default: byte_w = word_q[7:0];
        endcase
    end

    // Next-state logic: sequencing, address stepping, word counting
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        word_d      = word_q;
        byte_d      = byte_q;
        wrapped_d   = wrapped_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ck_d        = ck_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wrapped_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    ck_d      = 8'h00;
`endif
                    if (word_count != '0) begin
                        addr_d      = base_addr;
                        remaining_d = word_count;
                        state_d     = S_WAIT;
                    end else begin
                        // Empty load: report completion without touching memory
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    word_d  = in_word;
                    byte_d  = 2'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d = addr_q + 1'b1;
                if (&addr_q) begin
                    wrapped_d = 1'b1;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ck_d   = ck_q + byte_w;
`endif
                byte_d = byte_q + 1'b1;
                if (byte_q == 2'd3) begin
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == 1) ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any load in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            word_q      <= 32'h0;
            byte_q      <= 2'd0;
            wrapped_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ck_q        <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
            byte_q      <= byte_d;
            wrapped_q   <= wrapped_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ck_q        <= ck_d;
`endif
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        in_ready  = (state_q == S_WAIT);
        mem_we    = (state_q == S_WRITE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        mem_addr  = addr_q;
        mem_wdata = (state_q == S_WRITE) ? byte_w : 8'h00;
        wrapped   = wrapped_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum  = ck_q;
`else
        checksum  = 8'h00;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Scoreboard bench for imem_loader. Stimulus pushes expected
//            (address, byte) pairs; a negedge monitor pops and compares every
//            memory write and checks done timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              wrapped;
    logic [7:0]        checksum;

    imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .wrapped    (wrapped),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t               sb[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    int                last_we_cyc = 0;
    bit                we_since_done = 0;
    bit                done_prev = 0;
    logic [ADDR_W-1:0] exp_addr;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] exp_ck(input logic [7:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
        return s;
`else
        return (s & 8'h00);
`endif
    endfunction

    // Monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {22'h0, mem_addr}, 32'hFFFFFFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", {22'h0, mem_addr}, {22'h0, e.addr});
                check("wr_data", {24'h0, mem_wdata}, {24'h0, e.data});
            end
            last_we_cyc   = cyc;
            we_since_done = 1'b1;
        end
        if (done) begin
            check("done_single_cycle", {31'h0, done_prev}, 32'h0);
            if (we_since_done) begin
                check("done_after_last_we", cyc, last_we_cyc + 1);
            end
            we_since_done = 1'b0;
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        exp_addr   = b;
        tick();
        start      = 1'b0;
    endtask

    task automatic push_bytes(input logic [31:0] w, input int nbytes);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < nbytes; i++) begin
            sb.push_back({exp_addr, t[31:24]});
            t        = t << 8;
            exp_addr = exp_addr + 1'b1;
        end
    endtask

    // Present a word and hold it until accepted; returns in the first write cycle
    task automatic feed_word(input logic [31:0] w);
        int k;
        push_bytes(w, 4);
        in_valid = 1'b1;
        in_word  = w;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) check("in_ready_timeout", 32'h0, 32'h1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic exp_wr, input logic [7:0] sum,
                             input bit poke_start);
        int k;
        k = 0;
        while (!done && k < 30) begin
            tick();
            k++;
        end
        check({name, "_done"}, {31'h0, done}, 32'h1);
        check({name, "_wrapped"}, {31'h0, wrapped}, {31'h0, exp_wr});
        check({name, "_checksum"}, {24'h0, checksum}, {24'h0, exp_ck(sum)});
        if (poke_start) begin
            start      = 1'b1;
            word_count = 8'd1;
        end
        tick();
        start = 1'b0;
        check({name, "_idle_after"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_word = 32'h0; exp_addr = '0;
        tick(); tick();
        // Reset state
        check("rst_outputs", {26'h0, in_ready, mem_we, busy, done, wrapped, 1'b0},
              32'h0);
        check("rst_addr_data", {14'h0, mem_addr, mem_wdata}, 32'h0);
        check("rst_checksum", {24'h0, checksum}, 32'h0);
        rst = 1'b0;
        tick();

        // Test 1: two words from address 0
        start_load(10'h000, 8'd2);
        feed_word(32'h00FF550F);
        feed_word(32'hCC33F090);
        wait_done("t1", 1'b0, 8'hE2, 1'b0);

        // Test 2: wrap past the top of memory
        start_load(10'h3FE, 8'd1);
        feed_word(32'hA1B2C3D4);
        wait_done("t2", 1'b1, 8'hEA, 1'b0);

        // Test 3: zero-length load
        start_load(10'h123, 8'd0);
        check("t3_done", {30'h0, done, busy}, 32'h3);
        check("t3_no_we", {31'h0, mem_we}, 32'h0);
        tick();
        check("t3_idle", {30'h0, done, busy}, 32'h0);

        // Test 4: in_valid held low in WAIT
        start_load(10'h010, 8'd1);
        for (int i = 0; i < 3; i++) begin
            check("t4_wait_ready", {30'h0, in_ready, mem_we}, 32'h2);
            tick();
        end
        push_bytes(32'h11223344, 4);
        in_valid = 1'b1;
        in_word  = 32'h11223344;
        tick();
        in_valid = 1'b0;
        check("t4_write_starts", {30'h0, in_ready, mem_we}, 32'h1);
        wait_done("t4", 1'b0, 8'hAA, 1'b0);

        // Test 5: reset after two bytes of a word
        start_load(10'h100, 8'd1);
        push_bytes(32'hDEADBEEF, 2);
        in_valid = 1'b1;
        in_word  = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_we_busy", {30'h0, mem_we, busy}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        start_load(10'h000, 8'd2);
        feed_word(32'h00FF550F);
        feed_word(32'hCC33F090);
        wait_done("t5_rerun", 1'b0, 8'hE2, 1'b0);

        // Test 7: start while busy and start coinciding with done are ignored
        start_load(10'h040, 8'd1);
        feed_word(32'h01020304);
        start      = 1'b1;
        base_addr  = 10'h2AA;
        word_count = 8'd3;
        tick();
        start = 1'b0;
        wait_done("t7", 1'b0, 8'h0A, 1'b1);
        tick();
        check("t7_still_idle", {31'h0, busy}, 32'h0);

        repeat (3) tick();
        check("sb_empty", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
